instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 10: instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 clr  in  1  synchronous clear of pointer, count and err.
REQ-005 in_valid  in  1  request present; in_ready  out  1  block can accept.
REQ-006 mnem  in  4  0 addu, 1 subu, 2 slt, 3 jr, 4 addi, 5 addiu, 6 beq, 7 lui, 8 lw, 9 ori, 10 sw, 11 j, 12 jal; 13-15 illegal.
REQ-007 rs, rt, rd  in  5 each  register fields; imm  in  16  immediate; target  in  26  jump target; in_last  in  1  final instruction of program.
REQ-008 mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  32: instruction-memory write port.
REQ-009 count  out  ADDR_W+1  words written; full  out  1  count == DEPTH; err  out  1  sticky illegal-mnemonic flag; done  out  1  one-cycle end-of-program pulse.

Function
REQ-010 The FSM SHALL have states IDLE, ENC, WR and DONE.
REQ-011 in_ready SHALL equal (state==IDLE & !full & !clr & !rst).
REQ-012 In IDLE, the in_valid & in_ready edge SHALL latch all input fields and go to ENC; fields SHALL be ignored at all other times.
REQ-013 R-type words SHALL be op 000000 | rs | rt | rd | shamt 00000 | funct, with funct addu 100001, subu 100011, slt 101010 and jr 001000; jr SHALL force rt=rd=0.
REQ-014 I-type words SHALL be op | rs | rt | imm, with op addi 001000, addiu 001001, beq 000100, lui 001111 (rs forced 0), lw 100011, ori 001101, sw 101011.
REQ-015 J-type words SHALL be op | target, with op j 000010 and jal 000011.
REQ-016 ENC SHALL register the encoded word and go to WR; an illegal mnem SHALL set err, perform no write, and go to DONE if latched in_last=1, else to IDLE.
REQ-017 WR SHALL assert mem_we for exactly one cycle with mem_addr = pointer and mem_wdata = word; at that edge the pointer SHALL increment modulo DEPTH and count by 1; next state SHALL be DONE if in_last=1, else IDLE.
REQ-018 DONE SHALL assert done for one cycle, then return to IDLE; the pointer and count SHALL be retained.
REQ-019 Latency: accept at edge N, so mem_we is high in the cycle after edge N+1; throughput is at most one instruction per 3 cycles.
REQ-020 When count reaches DEPTH, full SHALL be 1 and in_ready 0 until clr or rst; the pointer wraps to 0 but no write occurs while full.
REQ-021 clr SHALL be honoured in any state: pointer, count and err go to 0, state goes to IDLE, and any in-flight instruction is aborted without a write; clr with in_valid in the same cycle SHALL accept nothing.
REQ-022 mem_we and done SHALL be 0 in every state other than WR and DONE respectively.

Reset
REQ-023 While rst=1: state=IDLE, pointer=0, count=0, err=0, mem_we=0, done=0, mem_addr=0, mem_wdata=0, in_ready=0; rst SHALL take priority over clr and abort any in-flight operation; in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-024 addu rs=1 rt=2 rd=3 at pointer 0 -> mem_we in 3rd cycle, addr 0, wdata 0x00221821, count=1.
REQ-025 lui rs=7 rt=4 imm=0x1234, then jal target=0x0000100 with in_last=1 -> wdata 0x3C041234 @0, then 0x0C000100 @1; done pulses one cycle after the 2nd write.
REQ-026 mnem=14 -> no mem_we, err=1 and stays 1; the next legal sw rs=29 rt=8 imm=0xFFFC -> 0xAFA8FFFC written at the unchanged pointer.
REQ-027 ADDR_W=2: four writes -> full=1, in_ready=0; a 5th in_valid is ignored; clr -> count=0, full=0, next write at addr 0.
REQ-028 rst or clr asserted in ENC -> no mem_we follows, count unchanged (clr: 0), state IDLE on the next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts one symbolic MIPS-style instruction at a time,
// packs it into a 32-bit machine word and writes it into the next free word
// of an instruction memory. Tracks how many words were written, flags illegal
// mnemonics (sticky) and pulses done after the last instruction of a program.
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
);

    // Mnemonic codes as presented on the mnem input
    localparam logic [3:0] M_ADDU  = 4'd0;
    localparam logic [3:0] M_SUBU  = 4'd1;
    localparam logic [3:0] M_SLT   = 4'd2;
    localparam logic [3:0] M_JR    = 4'd3;
    localparam logic [3:0] M_ADDI  = 4'd4;
    localparam logic [3:0] M_ADDIU = 4'd5;
    localparam logic [3:0] M_BEQ   = 4'd6;
    localparam logic [3:0] M_LUI   = 4'd7;
    localparam logic [3:0] M_LW    = 4'd8;
    localparam logic [3:0] M_ORI   = 4'd9;
    localparam logic [3:0] M_SW    = 4'd10;
    localparam logic [3:0] M_J     = 4'd11;
    localparam logic [3:0] M_JAL   = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    // Fields captured at acceptance; the live inputs are ignored afterwards
    logic [3:0]         mnem_reg;
    logic [4:0]         rs_reg;
    logic [4:0]         rt_reg;
    logic [4:0]         rd_reg;
    logic [15:0]        imm_reg;
    logic [25:0]        target_reg;
    logic               last_reg;

    logic [31:0]        word_reg;
    logic [31:0]        word_next;
    logic [ADDR_W-1:0]  ptr_reg;
    logic [ADDR_W:0]    count_reg;
    logic               err_reg;

    logic               legal;
    logic               accept;
    logic               load_word;
    logic               set_err;
    logic               write_fire;

    // Count never exceeds DEPTH, so its MSB alone marks the full condition
    assign full     = count_reg[ADDR_W];
    assign count    = count_reg;
    assign err      = err_reg;
    assign in_ready = (state_reg == IDLE) && !full && !clr && !rst;

    // A write is suppressed in the same cycle that rst or clr aborts it
    assign mem_we    = (state_reg == WR) && !rst && !clr;
    assign done      = (state_reg == DONE) && !rst;
    assign mem_addr  = rst ? '0 : ptr_reg;
    assign mem_wdata = rst ? '0 : word_reg;

    assign legal = (mnem_reg <= M_JAL);

    // Pack the latched fields into R-, I- or J-type machine words
    always_comb begin
        word_next = 32'h0000_0000;
        case (mnem_reg)
            M_ADDU:  word_next = {6'b000000, rs_reg, rt_reg, rd_reg, 5'b00000, 6'b100001};
            M_SUBU:  word_next = {6'b000000, rs_reg, rt_reg, rd_reg, 5'b00000, 6'b100011};
            M_SLT:   word_next = {6'b000000, rs_reg, rt_reg, rd_reg, 5'b00000, 6'b101010};
            // jr only uses rs; rt and rd are architecturally zero
            M_JR:    word_next = {6'b000000, rs_reg, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
            M_ADDI:  word_next = {6'b001000, rs_reg, rt_reg, imm_reg};
            M_ADDIU: word_next = {6'b001001, rs_reg, rt_reg, imm_reg};
            M_BEQ:   word_next = {6'b000100, rs_reg, rt_reg, imm_reg};
            // lui has no source register; rs is zero in the encoding
            M_LUI:   word_next = {6'b001111, 5'b00000, rt_reg, imm_reg};
            M_LW:    word_next = {6'b100011, rs_reg, rt_reg, imm_reg};
            M_ORI:   word_next = {6'b001101, rs_reg, rt_reg, imm_reg};
            M_SW:    word_next = {6'b101011, rs_reg, rt_reg, imm_reg};
            M_J:     word_next = {6'b000010, target_reg};
            M_JAL:   word_next = {6'b000011, target_reg};
            default: word_next = 32'h0000_0000;
        endcase
    end

    // Next-state and per-cycle action strobes; clr overrides everything
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        load_word  = 1'b0;
        set_err    = 1'b0;
        write_fire = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = ENC;
                end
            end
            ENC: begin
                if (legal) begin
                    load_word  = 1'b1;
                    state_next = WR;
                end else begin
                    set_err    = 1'b1;
                    state_next = last_reg ? DONE : IDLE;
                end
            end
            WR: begin
                write_fire = 1'b1;
                state_next = last_reg ? DONE : IDLE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clr) begin
            accept     = 1'b0;
            load_word  = 1'b0;
            set_err    = 1'b0;
            write_fire = 1'b0;
            state_next = IDLE;
        end
    end

    // State register; rst wins over clr, clr is already folded into state_next
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the request fields on the accepting edge only
    always_ff @(posedge clk) begin
        if (rst) begin
            mnem_reg   <= 4'd0;
            rs_reg     <= 5'd0;
            rt_reg     <= 5'd0;
            rd_reg     <= 5'd0;
            imm_reg    <= 16'd0;
            target_reg <= 26'd0;
            last_reg   <= 1'b0;
        end else if (accept) begin
            mnem_reg   <= mnem;
            rs_reg     <= rs;
            rt_reg     <= rt;
            rd_reg     <= rd;
            imm_reg    <= imm;
            target_reg <= target;
            last_reg   <= in_last;
        end
    end

    // Encoded word holding register, loaded in ENC and presented during WR
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg <= 32'h0000_0000;
        end else if (load_word) begin
            word_reg <= word_next;
        end
    end

    // Write pointer, word count and sticky error flag
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (write_fire) begin
                ptr_reg   <= ptr_reg + ADDR_W'(1);
                count_reg <= count_reg + (ADDR_W+1)'(1);
            end
            if (set_err) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized testbench for instr_encoder with a transaction-level reference
// model (pointer, count, sticky error and an arithmetic instruction packer).
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic              done;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mnem      (mnem),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .target    (target),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference model state
    int m_ptr   = 0;
    int m_count = 0;
    bit m_err   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Machine word from the mnemonic tables: opcode at bit 26, fields below
    function automatic logic [31:0] ref_word(input logic [3:0] m, input logic [4:0] s,
                                             input logic [4:0] t, input logic [4:0] d,
                                             input logic [15:0] i, input logic [25:0] tg);
        logic [31:0] op;
        logic [31:0] fn;
        logic [31:0] sv;
        logic [31:0] tv;
        logic [31:0] dv;
        op = 32'd0;
        fn = 32'd0;
        sv = 32'(s);
        tv = 32'(t);
        dv = 32'(d);
        case (m)
            4'd0:  fn = 32'd33;
            4'd1:  fn = 32'd35;
            4'd2:  fn = 32'd42;
            4'd3:  fn = 32'd8;
            4'd4:  op = 32'd8;
            4'd5:  op = 32'd9;
            4'd6:  op = 32'd4;
            4'd7:  op = 32'd15;
            4'd8:  op = 32'd35;
            4'd9:  op = 32'd13;
            4'd10: op = 32'd43;
            4'd11: op = 32'd2;
            4'd12: op = 32'd3;
            default: op = 32'd0;
        endcase
        if (m == 4'd3) begin
            tv = 32'd0;
            dv = 32'd0;
        end
        if (m == 4'd7) sv = 32'd0;
        if (m <= 4'd3)
            return (sv << 21) + (tv << 16) + (dv << 11) + fn;
        else if (m <= 4'd10)
            return (op << 26) + (sv << 21) + (tv << 16) + 32'(i);
        else
            return (op << 26) + 32'(tg);
    endfunction

    task automatic drive_junk();
        mnem    = 4'($urandom);
        rs      = 5'($urandom);
        rt      = 5'($urandom);
        rd      = 5'($urandom);
        imm     = 16'($urandom);
        target  = 26'($urandom);
        in_last = 1'($urandom);
    endtask

    // One instruction from request to settled IDLE; called at negedge+1
    task automatic issue(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg,
                         input logic last);
        logic [31:0] expw;
        bit          legal;
        int          addr;
        expw  = ref_word(m, s, t, d, i, tg);
        legal = (m <= 4'd12);
        addr  = m_ptr;
        mnem = m; rs = s; rt = t; rd = d; imm = i; target = tg; in_last = last;
        in_valid = 1'b1;
        #1;
        if (m_count == DEPTH) begin
            check("ready_full", in_ready, 0);
            repeat (3) begin
                @(negedge clk); #1;
                check("we_full", mem_we, 0);
            end
            in_valid = 1'b0;
            check("count_full", count, m_count);
            check("full_held", full, 1);
            n_txn++;
            $display("txn %0d: mnem=%0d ignored (full) count=%0d", n_txn, m, m_count);
            return;
        end
        check("ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        drive_junk();
        #1;
        check("we_enc", mem_we, 0);
        check("done_enc", done, 0);
        if (legal) begin
            @(negedge clk);
            drive_junk();
            #1;
            check("we_wr", mem_we, 1);
            check("addr_wr", mem_addr, m_ptr);
            check("wdata_wr", mem_wdata, expw);
            m_ptr   = (m_ptr + 1) % DEPTH;
            m_count = m_count + 1;
        end else begin
            m_err = 1'b1;
        end
        @(negedge clk);
        drive_junk();
        #1;
        check("we_post", mem_we, 0);
        check("done_post", done, last);
        if (last) begin
            @(negedge clk); #1;
            check("done_off", done, 0);
        end
        check("count", count, m_count);
        check("err", err, m_err);
        check("full", full, m_count == DEPTH);
        check("ready_idle", in_ready, m_count != DEPTH);
        n_txn++;
        $display("txn %0d: mnem=%0d last=%0d legal=%0d addr=%0d word=%08h count=%0d",
                 n_txn, m, last, legal, addr, expw, m_count);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        #1;
        check("ready_clr", in_ready, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        m_ptr = 0; m_count = 0; m_err = 1'b0;
        check("count_clr", count, 0);
        check("full_clr", full, 0);
        check("err_clr", err, 0);
        check("ready_after_clr", in_ready, 1);
        n_txn++;
        $display("txn %0d: clr", n_txn);
    endtask

    // Accept a legal instruction, then kill it in ENC with rst or clr
    task automatic abort_enc(input bit use_rst);
        mnem = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; in_last = 1'b0;
        in_valid = 1'b1;
        #1;
        check("ready_abort", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        if (use_rst) rst = 1'b1; else clr = 1'b1;
        #1;
        check("we_abort", mem_we, 0);
        @(negedge clk);
        rst = 1'b0; clr = 1'b0;
        #1;
        m_ptr = 0; m_count = 0; m_err = 1'b0;
        check("we_after_abort", mem_we, 0);
        check("count_abort", count, 0);
        check("ready_abort_idle", in_ready, 1);
        @(negedge clk); #1;
        check("we_after_abort2", mem_we, 0);
        n_txn++;
        $display("txn %0d: abort in ENC via %s", n_txn, use_rst ? "rst" : "clr");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rm;
        int r;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
        mnem = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; target = 26'd0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);

        // Basic addu, then start a fresh program for the lui/jal pair
        issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        do_clr();
        issue(4'd7, 5'd7, 5'd4, 5'd0, 16'h1234, 26'h0, 1'b0);
        issue(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100, 1'b1);
        // Illegal mnemonic, then sw lands at the unchanged pointer
        issue(4'd14, 5'd3, 5'd3, 5'd3, 16'h5555, 26'h0, 1'b0);
        issue(4'd10, 5'd29, 5'd8, 5'd0, 16'hFFFC, 26'h0, 1'b0);
        // Fill the last slot, then a further request must be ignored
        issue(4'd3, 5'd31, 5'd9, 5'd9, 16'h0, 26'h0, 1'b0);
        issue(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
        do_clr();
        issue(4'd2, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 1'b0);
        abort_enc(1'b1);
        abort_enc(1'b0);

        // clr together with in_valid must accept nothing
        mnem = 4'd4; rs = 5'd1; rt = 5'd1; imm = 16'h7; in_last = 1'b0;
        in_valid = 1'b1; clr = 1'b1;
        #1;
        check("ready_clr_valid", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        #1;
        m_ptr = 0; m_count = 0; m_err = 1'b0;
        check("we_clr_valid", mem_we, 0);
        @(negedge clk); #1;
        check("we_clr_valid2", mem_we, 0);
        check("count_clr_valid", count, 0);

        for (int k = 0; k < 200; k++) begin
            if ((m_count == DEPTH && $urandom_range(1, 0) == 1) || $urandom_range(19, 0) == 0) begin
                do_clr();
            end else begin
                r = $urandom_range(99, 0);
                rm = (r < 10) ? 4'(13 + r % 3) : 4'($urandom_range(12, 0));
                issue(rm, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                      26'($urandom), 1'($urandom_range(3, 0) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
